// File: rtl/sn_spike_capture_fifo_if.sv
// Protocol register bus between the host bridge and the spike capture FIFO.
// 7-bit address, 8-bit data, single-cycle strobed accesses.
interface sn_spike_capture_fifo_if;
  logic       enable;
  logic       r0w1;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       hit;

  modport master (
    output enable,
    output r0w1,
    output addr,
    output wdata,
    input  rdata,
    input  hit
  );

  modport slave (
    input  enable,
    input  r0w1,
    input  addr,
    input  wdata,
    output rdata,
    output hit
  );
endinterface

// File: rtl/sn_spike_capture_fifo.sv
// Captures timestamped output-spike vectors per evaluation step into a FIFO
// that the host drains byte-wise through the protocol register window.
module sn_spike_capture_fifo #(
  parameter int         P_NUM_OUTPUTS = 1,
  parameter int         P_TS_BW       = 16,
  parameter int         P_FIFO_DEPTH  = 16,
  parameter logic [6:0] P_BASE_ADDR   = 7'h60
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     nc_evaluate,
  input  logic [P_NUM_OUTPUTS-1:0] out_spikes,
  sn_spike_capture_fifo_if.slave   prot,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic                     overflow
);

  localparam int W  = P_TS_BW + P_NUM_OUTPUTS;
  localparam int NB = (W + 7) / 8;
  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0]    LAST  = 7'(3 + NB - 1);
  localparam logic [CW-1:0] DEPTH = CW'(P_FIFO_DEPTH);

  logic [W-1:0]       mem [P_FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [P_TS_BW-1:0] ts;
  logic               cap_en;

  logic [6:0]  off;
  logic        hit;
  logic        rd;
  logic        wr;
  logic        sel_status;
  logic        sel_count;
  logic        sel_ctrl;
  logic        sel_data;
  logic        ctrl_wr;
  logic        fifo_clr;
  logic        ovf_clr;
  logic        ts_clr;
  logic        push_req;
  logic        push;
  logic        pop;
  logic        drop;
  logic [31:0] head_ext;
  logic [1:0]  bsel;
  logic [7:0]  data_byte;
  logic [7:0]  rdata;
  logic        unused_wdata;

  assign off = prot.addr - P_BASE_ADDR;
  assign hit = (prot.addr >= P_BASE_ADDR) && (off <= 7'd6);
  assign rd  = prot.enable && !prot.r0w1 && hit;
  assign wr  = prot.enable && prot.r0w1 && hit;

  assign sel_status = (off == 7'd0);
  assign sel_count  = (off == 7'd1);
  assign sel_ctrl   = (off == 7'd2);
  assign sel_data   = (off >= 7'd3);

  assign ctrl_wr  = wr && sel_ctrl;
  assign fifo_clr = ctrl_wr && prot.wdata[1];
  assign ovf_clr  = ctrl_wr && prot.wdata[2];
  assign ts_clr   = ctrl_wr && prot.wdata[3];
  assign unused_wdata = ^prot.wdata[7:4];

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH);

  // Only the final byte of an entry pops; an empty FIFO never pops.
  assign pop      = rd && (off == LAST) && !fifo_empty;
  assign push_req = nc_evaluate && cap_en && (|out_spikes);
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  assign head_ext  = 32'(mem[rd_ptr]);
  assign bsel      = 2'(off - 7'd3);
  assign data_byte = 8'(head_ext >> {bsel, 3'b000});

  always_comb begin
    rdata = '0;
    if (rd) begin
      unique case (1'b1)
        sel_status:
          rdata = {4'b0, cap_en, overflow,
                   fifo_full, fifo_empty};
        sel_count:
          rdata = 8'(count);
        sel_ctrl:
          rdata = {7'b0, cap_en};
        sel_data:
          if (!fifo_empty && off <= LAST)
            rdata = data_byte;
        default:
          rdata = '0;
      endcase
    end
  end

  assign prot.rdata = rdata;
  assign prot.hit   = hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ts       <= '0;
      cap_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr)
        cap_en <= prot.wdata[0];

      if (ts_clr)
        ts <= '0;
      else if (nc_evaluate && cap_en)
        ts <= ts + 1'b1;

      if (ovf_clr)
        overflow <= 1'b0;
      else if (drop)
        overflow <= 1'b1;

      if (fifo_clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {ts, out_spikes};
  end

endmodule

// File: tb/tb_sn_spike_capture_fifo.sv
// Self-checking bench for the spike capture FIFO: reset register table,
// scoreboard-checked drains, full/overflow, wrap, strobes and reset.
module tb_sn_spike_capture_fifo;

  localparam logic [6:0] BASE = 7'h60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic nc_evaluate = 1'b0;
  logic [0:0] out_spikes = 1'b0;
  logic fifo_empty;
  logic fifo_full;
  logic overflow;

  sn_spike_capture_fifo_if bus ();

  sn_spike_capture_fifo #(
    .P_NUM_OUTPUTS(1),
    .P_TS_BW(16),
    .P_FIFO_DEPTH(16),
    .P_BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .nc_evaluate(nc_evaluate),
    .out_spikes(out_spikes),
    .prot(bus),
    .fifo_empty(fifo_empty),
    .fifo_full(fifo_full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [16:0] sb [$];
  logic [15:0] m_ts = '0;
  logic        m_cap = 1'b0;
  logic        m_ovf = 1'b0;

  typedef struct {
    logic       en;
    logic [6:0] addr;
    logic [7:0] rdata;
    logic       hit;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    return {4'b0, m_cap, m_ovf,
            sb.size() == 16, sb.size() == 0};
  endfunction

  task automatic reg_rd(input logic [6:0] o,
                        output logic [7:0] d);
    @(negedge clk);
    bus.enable = 1'b1;
    bus.r0w1   = 1'b0;
    bus.addr   = BASE + o;
    #1 d = bus.rdata;
    @(posedge clk);
    #1 bus.enable = 1'b0;
    if (o == 7'd5 && sb.size() > 0)
      void'(sb.pop_front());
  endtask

  task automatic reg_wr(input logic [6:0] o,
                        input logic [7:0] v);
    @(negedge clk);
    bus.enable = 1'b1;
    bus.r0w1   = 1'b1;
    bus.addr   = BASE + o;
    bus.wdata  = v;
    @(posedge clk);
    #1 bus.enable = 1'b0;
    bus.r0w1 = 1'b0;
    if (o == 7'd2) begin
      m_cap = v[0];
      if (v[1]) sb.delete();
      if (v[2]) m_ovf = 1'b0;
      if (v[3]) m_ts = '0;
    end
  endtask

  task automatic model_eval(input logic s);
    if (m_cap) begin
      if (s) begin
        if (sb.size() < 16) sb.push_back({m_ts, s});
        else m_ovf = 1'b1;
      end
      m_ts = m_ts + 1'b1;
    end
  endtask

  task automatic eval(input logic s);
    @(negedge clk);
    nc_evaluate = 1'b1;
    out_spikes  = s;
    @(posedge clk);
    #1 nc_evaluate = 1'b0;
    model_eval(s);
  endtask

  task automatic burst_zero(input int n);
    @(negedge clk);
    nc_evaluate = 1'b1;
    out_spikes  = 1'b0;
    repeat (n) @(posedge clk);
    #1 nc_evaluate = 1'b0;
    if (m_cap) m_ts = m_ts + 16'(n);
  endtask

  task automatic pop_check(input string name,
                           output logic [23:0] got);
    logic [7:0]  b0, b1, b2;
    logic [23:0] exp;
    exp = sb.size() > 0 ? 24'(sb[0]) : 24'h0;
    reg_rd(7'd3, b0);
    reg_rd(7'd4, b1);
    reg_rd(7'd5, b2);
    got = {b2, b1, b0};
    chk(name, 32'(got), 32'(exp));
  endtask

  logic [7:0]  d;
  logic [23:0] e;
  logic [23:0] exp_e;

  initial begin
    vt[0] = '{1'b1, 7'h60, 8'h01, 1'b1};
    vt[1] = '{1'b1, 7'h61, 8'h00, 1'b1};
    vt[2] = '{1'b1, 7'h62, 8'h00, 1'b1};
    vt[3] = '{1'b1, 7'h63, 8'h00, 1'b1};
    vt[4] = '{1'b1, 7'h65, 8'h00, 1'b1};
    vt[5] = '{1'b1, 7'h66, 8'h00, 1'b1};
    vt[6] = '{1'b1, 7'h5F, 8'h00, 1'b0};
    vt[7] = '{1'b1, 7'h67, 8'h00, 1'b0};
    vt[8] = '{1'b0, 7'h60, 8'h00, 1'b1};
    vt[9] = '{1'b1, 7'h00, 8'h00, 1'b0};

    bus.enable = 1'b0;
    bus.r0w1   = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset register map
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.enable = vt[i].en;
      bus.r0w1   = 1'b0;
      bus.addr   = vt[i].addr;
      #1;
      chk($sformatf("vec%0d_rdata", i),
          32'(bus.rdata), 32'(vt[i].rdata));
      chk($sformatf("vec%0d_hit", i),
          32'(bus.hit), 32'(vt[i].hit));
      @(posedge clk);
      #1 bus.enable = 1'b0;
    end
    reg_rd(7'd1, d);
    chk("rst_count_after_data", 32'(d), 0);
    reg_rd(7'd0, d);
    chk("rst_status_after_data", 32'(d), 32'h01);

    // basic capture and first drain
    reg_wr(7'd2, 8'h01);
    eval(1'b0);
    eval(1'b1);
    eval(1'b1);
    reg_rd(7'd1, d);
    chk("t2_count", 32'(d), 2);
    reg_rd(7'd2, d);
    chk("t2_ctrl_rb", 32'(d), 32'h01);
    reg_wr(7'd0, 8'hFF);
    reg_wr(7'd5, 8'hFF);
    reg_rd(7'd0, d);
    chk("t2_ro_write", 32'(d), 32'(exp_status()));
    pop_check("t2_entry0", e);
    chk("t2_entry0_bytes", 32'(e), 32'h000003);
    reg_rd(7'd1, d);
    chk("t2_count_after_pop", 32'(d), 1);

    // fill and overflow
    repeat (15) eval(1'b1);
    #1;
    chk("t3_full", 32'(fifo_full), 1);
    chk("t3_ovf_pre", 32'(overflow), 0);
    eval(1'b1);
    #1;
    chk("t3_ovf", 32'(overflow), 1);
    reg_rd(7'd0, d);
    chk("t3_status", 32'(d), 32'h0E);
    chk("t3_status_model", 32'(d), 32'(exp_status()));
    reg_rd(7'd1, d);
    chk("t3_count", 32'(d), 16);
    reg_wr(7'd2, 8'h05);
    #1;
    chk("t3_ovf_clr", 32'(overflow), 0);
    reg_rd(7'd0, d);
    chk("t3_status_clr", 32'(d), 32'h0A);

    // same-cycle pop and push while full
    reg_rd(7'd3, e[7:0]);
    reg_rd(7'd4, e[15:8]);
    exp_e = 24'(sb.pop_front());
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.r0w1    = 1'b0;
    bus.addr    = BASE + 7'd5;
    nc_evaluate = 1'b1;
    out_spikes  = 1'b1;
    #1 e[23:16] = bus.rdata;
    @(posedge clk);
    #1 bus.enable = 1'b0;
    nc_evaluate = 1'b0;
    model_eval(1'b1);
    chk("t4_popped", 32'(e), 32'(exp_e));
    chk("t4_ovf", 32'(overflow), 0);
    reg_rd(7'd1, d);
    chk("t4_count", 32'(d), 16);
    for (int i = 0; i < 16; i++)
      pop_check($sformatf("t4_drain%0d", i), e);
    chk("t4_last_ts", 32'(e[16:1]), 32'(m_ts - 16'd1));
    reg_rd(7'd0, d);
    chk("t4_empty_status", 32'(d), 32'h09);
    reg_rd(7'd5, d);
    chk("t4_empty_data", 32'(d), 0);
    reg_rd(7'd1, d);
    chk("t4_empty_count", 32'(d), 0);

    // timestamp wrap and ts_clr
    reg_wr(7'd2, 8'h09);
    burst_zero(65535);
    reg_rd(7'd1, d);
    chk("t5_no_zero_push", 32'(d), 0);
    eval(1'b1);
    eval(1'b1);
    pop_check("t5_entry_ffff", e);
    chk("t5_ts_ffff", 32'(e[16:1]), 32'hFFFF);
    pop_check("t5_entry_0000", e);
    chk("t5_ts_0000", 32'(e[16:1]), 32'h0000);
    eval(1'b0);
    reg_wr(7'd2, 8'h09);
    eval(1'b1);
    pop_check("t5_entry_clr", e);
    chk("t5_ts_clr", 32'(e[16:1]), 32'h0000);

    // fifo_clr strobe
    eval(1'b1);
    eval(1'b1);
    reg_wr(7'd2, 8'h03);
    reg_rd(7'd1, d);
    chk("clr_count", 32'(d), 0);
    reg_rd(7'd2, d);
    chk("clr_ctrl_rb", 32'(d), 32'h01);

    // reset mid-drain
    eval(1'b1);
    eval(1'b1);
    eval(1'b1);
    pop_check("t6_pre_rst", e);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_empty", 32'(fifo_empty), 1);
    sb.delete();
    m_cap = 1'b0;
    m_ovf = 1'b0;
    m_ts  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    reg_rd(7'd1, d);
    chk("t6_count", 32'(d), 0);
    reg_rd(7'd0, d);
    chk("t6_status", 32'(d), 32'h01);
    eval(1'b1);
    reg_rd(7'd1, d);
    chk("t6_no_cap", 32'(d), 0);
    reg_wr(7'd2, 8'h01);
    eval(1'b1);
    pop_check("t6_after_en", e);
    chk("t6_entry", 32'(e), 32'h000001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
